mips_cpu_dmem_bridge: RTL and testbench

Sits directly downstream of the Harvard CPU's data port. Converts the CPU's combinational, single-cycle data-memory interface (address/read/write/writedata in, readdata expected same cycle) into a registered Avalon-MM-style master with `waitrequest`. It stalls the CPU through its clock-enable until each access completes, and presents the captured read data during the CPU's single enabled cycle.

---
 rtl/mips_cpu_pkg.sv | 13 +
 rtl/mips_cpu_dmem_bridge.sv | 125 ++++++++++++
 tb/tb_mips_cpu_dmem_bridge.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types and constants for the MIPS CPU data-memory bridge
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS   = 2'd1,
        DONE  = 2'd2,
        FAULT = 2'd3
    } dmem_state_t;

    localparam logic [3:0] DMEM_BYTEENABLE_ALL = 4'hF;

endpackage

// File: rtl/mips_cpu_dmem_bridge.sv
// rtl/mips_cpu_dmem_bridge.sv - stalls the CPU while a registered Avalon-MM style access completes
module mips_cpu_dmem_bridge
    import mips_cpu_pkg::*;
#(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ext_clk_enable,
    input  logic        cpu_active,
    input  logic [31:0] cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    output logic [31:0] cpu_readdata,
    output logic        cpu_clk_enable,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        err,
    output logic [31:0] stall_count
);

    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT);

    dmem_state_t state;
    logic        dir_write;
    logic [31:0] rdata_q;
    logic [31:0] wait_cnt;
    logic        cpu_req;
    logic        internal_enable;

    assign cpu_req        = cpu_active & (cpu_read | cpu_write);
    assign avm_byteenable = DMEM_BYTEENABLE_ALL;
    assign cpu_readdata   = rdata_q;
    assign cpu_clk_enable = ext_clk_enable & internal_enable;

    // The CPU only runs when no access is pending or the finished result is on offer.
    always_comb begin
        internal_enable = 1'b0;
        case (state)
            IDLE:    internal_enable = ~cpu_req;
            BUS:     internal_enable = 1'b0;
            DONE:    internal_enable = 1'b1;
            FAULT:   internal_enable = 1'b0;
            default: internal_enable = 1'b0;
        endcase
    end

    // Access sequencer: latch the request, hold the strobe until the bus accepts, then hand the result back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            dir_write     <= 1'b0;
            avm_address   <= 32'h0;
            avm_writedata <= 32'h0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            rdata_q       <= 32'h0;
            wait_cnt      <= 32'h0;
            err           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        // A simultaneous read+write resolves to a write; both it and a
                        // misaligned address are flagged but still carried out.
                        avm_address   <= {cpu_address[31:2], 2'b00};
                        avm_writedata <= cpu_writedata;
                        dir_write     <= cpu_write;
                        avm_write     <= cpu_write;
                        avm_read      <= ~cpu_write;
                        wait_cnt      <= 32'h0;
                        state         <= BUS;
                        if ((cpu_read & cpu_write) || (cpu_address[1:0] != 2'b00)) begin
                            err <= 1'b1;
                        end
                    end
                end
                BUS: begin
                    if (!avm_waitrequest) begin
                        if (!dir_write) begin
                            rdata_q <= avm_readdata;
                        end
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        state     <= DONE;
                    end else if (wait_cnt + 32'd1 >= TIMEOUT_LIMIT) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        err       <= 1'b1;
                        state     <= FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DONE: begin
                    // Leave only once the CPU has actually been clocked with the result.
                    if (ext_clk_enable) begin
                        state <= IDLE;
                    end
                end
                FAULT: begin
                    avm_read  <= 1'b0;
                    avm_write <= 1'b0;
                end
                default: state <= FAULT;
            endcase
        end
    end

    // Counts cycles the CPU would have run but was held back by this bridge; saturates.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_count <= 32'h0;
        end else if (ext_clk_enable && !internal_enable && (stall_count != 32'hFFFF_FFFF)) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_mips_cpu_dmem_bridge.sv
// tb/tb_mips_cpu_dmem_bridge.sv - directed-vector bench for mips_cpu_dmem_bridge
module tb_mips_cpu_dmem_bridge;

    logic        clk;
    logic        reset;
    logic        ext_clk_enable;
    logic        cpu_active;
    logic [31:0] cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_clk_enable;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;
    logic        err;
    logic [31:0] stall_count;

    int vec_cnt;
    int miss_cnt;

    mips_cpu_dmem_bridge #(.TIMEOUT(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .ext_clk_enable  (ext_clk_enable),
        .cpu_active      (cpu_active),
        .cpu_address     (cpu_address),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_writedata   (cpu_writedata),
        .cpu_readdata    (cpu_readdata),
        .cpu_clk_enable  (cpu_clk_enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_byteenable  (avm_byteenable),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest),
        .err             (err),
        .stall_count     (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_cnt         = 0;
        miss_cnt        = 0;
        reset           = 1'b0;
        ext_clk_enable  = 1'b1;
        cpu_active      = 1'b1;
        cpu_address     = 32'h0;
        cpu_read        = 1'b0;
        cpu_write       = 1'b0;
        cpu_writedata   = 32'h0;
        avm_readdata    = 32'h0;
        avm_waitrequest = 1'b0;
        step();
        step();
        check_vec("rst_read", 32'(avm_read), 32'h0);
        check_vec("rst_write", 32'(avm_write), 32'h0);
        check_vec("rst_err", 32'(err), 32'h0);
        check_vec("rst_stall", stall_count, 32'h0);
        check_vec("rst_addr", avm_address, 32'h0);
        check_vec("rst_clken", 32'(cpu_clk_enable), 32'h1);
        check_vec("byteen", 32'(avm_byteenable), 32'hF);
        reset = 1'b1;
        step();
        check_vec("idle_run", 32'(cpu_clk_enable), 32'h1);
        check_vec("idle_stall", stall_count, 32'h0);

        // Zero-wait read
        cpu_read     = 1'b1;
        cpu_address  = 32'h0000_1004;
        avm_readdata = 32'hDEAD_BEEF;
        #1;
        check_vec("rd0_en_c0", 32'(cpu_clk_enable), 32'h0);
        check_vec("rd0_strobe_c0", 32'(avm_read), 32'h0);
        step();
        check_vec("rd0_en_c1", 32'(cpu_clk_enable), 32'h0);
        check_vec("rd0_strobe_c1", 32'(avm_read), 32'h1);
        check_vec("rd0_addr", avm_address, 32'h0000_1004);
        check_vec("rd0_nowr", 32'(avm_write), 32'h0);
        step();
        check_vec("rd0_en_c2", 32'(cpu_clk_enable), 32'h1);
        check_vec("rd0_strobe_c2", 32'(avm_read), 32'h0);
        check_vec("rd0_data", cpu_readdata, 32'hDEAD_BEEF);
        check_vec("rd0_stall", stall_count, 32'd2);
        cpu_read = 1'b0;
        step();
        check_vec("rd0_back_idle", 32'(cpu_clk_enable), 32'h1);
        check_vec("rd0_stall_hold", stall_count, 32'd2);

        // Write with three wait states
        cpu_write       = 1'b1;
        cpu_address     = 32'h0000_2000;
        cpu_writedata   = 32'h1234_5678;
        avm_waitrequest = 1'b1;
        #1;
        check_vec("wr3_en_idle", 32'(cpu_clk_enable), 32'h0);
        step();
        for (int i = 0; i < 4; i++) begin
            avm_waitrequest = (i < 3);
            #1;
            check_vec($sformatf("wr3_strobe_%0d", i), 32'(avm_write), 32'h1);
            check_vec($sformatf("wr3_data_%0d", i), avm_writedata, 32'h1234_5678);
            check_vec($sformatf("wr3_en_%0d", i), 32'(cpu_clk_enable), 32'h0);
            step();
        end
        check_vec("wr3_strobe_end", 32'(avm_write), 32'h0);
        check_vec("wr3_en_done", 32'(cpu_clk_enable), 32'h1);
        check_vec("wr3_stall", stall_count, 32'd7);
        check_vec("wr3_err", 32'(err), 32'h0);
        cpu_write       = 1'b0;
        avm_waitrequest = 1'b0;
        step();

        // Misaligned address with read and write both high
        cpu_read      = 1'b1;
        cpu_write     = 1'b1;
        cpu_address   = 32'h0000_0006;
        cpu_writedata = 32'hA5A5_0001;
        step();
        check_vec("mis_write", 32'(avm_write), 32'h1);
        check_vec("mis_noread", 32'(avm_read), 32'h0);
        check_vec("mis_addr", avm_address, 32'h0000_0004);
        check_vec("mis_err", 32'(err), 32'h1);
        step();
        check_vec("mis_done_en", 32'(cpu_clk_enable), 32'h1);
        check_vec("mis_strobe_end", 32'(avm_write), 32'h0);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        step();
        check_vec("mis_err_sticky", 32'(err), 32'h1);
        check_vec("mis_stall", stall_count, 32'd9);

        // External enable low while in DONE
        cpu_read     = 1'b1;
        cpu_address  = 32'h0000_0020;
        avm_readdata = 32'hCAFE_F00D;
        step();
        step();
        check_vec("ext_done_data", cpu_readdata, 32'hCAFE_F00D);
        ext_clk_enable = 1'b0;
        avm_readdata   = 32'h0BAD_0BAD;
        for (int i = 0; i < 2; i++) begin
            #1;
            check_vec($sformatf("ext_low_en_%0d", i), 32'(cpu_clk_enable), 32'h0);
            check_vec($sformatf("ext_low_data_%0d", i), cpu_readdata, 32'hCAFE_F00D);
            check_vec($sformatf("ext_low_strobe_%0d", i), 32'(avm_read), 32'h0);
            step();
        end
        check_vec("ext_low_stall", stall_count, 32'd11);
        ext_clk_enable = 1'b1;
        #1;
        check_vec("ext_high_en", 32'(cpu_clk_enable), 32'h1);
        check_vec("ext_high_data", cpu_readdata, 32'hCAFE_F00D);
        // Next instruction is again a read; it should be sampled only now, in IDLE.
        cpu_address     = 32'h0000_0040;
        avm_waitrequest = 1'b1;
        step();
        check_vec("ext_idle_en", 32'(cpu_clk_enable), 32'h0);
        check_vec("ext_idle_strobe", 32'(avm_read), 32'h0);
        step();
        check_vec("rst_bus_strobe", 32'(avm_read), 32'h1);
        check_vec("rst_bus_addr", avm_address, 32'h0000_0040);

        // Asynchronous reset mid-BUS
        #2;
        reset    = 1'b0;
        cpu_read = 1'b0;
        #1;
        check_vec("rst_mid_strobe", 32'(avm_read), 32'h0);
        check_vec("rst_mid_err", 32'(err), 32'h0);
        check_vec("rst_mid_stall", stall_count, 32'h0);
        check_vec("rst_mid_data", cpu_readdata, 32'h0);
        check_vec("rst_mid_en", 32'(cpu_clk_enable), 32'h1);
        step();
        reset = 1'b1;
        step();
        check_vec("rst_rel_en", 32'(cpu_clk_enable), 32'h1);
        check_vec("rst_rel_strobe", 32'(avm_read), 32'h0);

        // Timeout with waitrequest stuck high (TIMEOUT = 4)
        cpu_read    = 1'b1;
        cpu_address = 32'h0000_0100;
        step();
        for (int i = 0; i < 4; i++) begin
            check_vec($sformatf("to_strobe_%0d", i), 32'(avm_read), 32'h1);
            check_vec($sformatf("to_err_%0d", i), 32'(err), 32'h0);
            step();
        end
        check_vec("to_strobe_drop", 32'(avm_read), 32'h0);
        check_vec("to_err", 32'(err), 32'h1);
        check_vec("to_en", 32'(cpu_clk_enable), 32'h0);
        check_vec("to_stall", stall_count, 32'd5);
        cpu_read        = 1'b0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_vec($sformatf("to_hold_en_%0d", i), 32'(cpu_clk_enable), 32'h0);
            check_vec($sformatf("to_hold_strobe_%0d", i), 32'(avm_read | avm_write), 32'h0);
        end
        check_vec("to_stall_hold", stall_count, 32'd8);
        reset = 1'b0;
        #1;
        check_vec("to_rst_en", 32'(cpu_clk_enable), 32'h1);
        check_vec("to_rst_err", 32'(err), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
